// File: rtl/sc_shift_arbiter.sv
// sc_shift_arbiter: shares the single player shift-register datapath between the
// JUG1 and JUG2 controllers. Each requester owns a one-entry pending slot; one
// command is granted at a time, followed by a hold-off of HOLDOFF_CYCLES cycles.
// Optional feature: define SC_SHIFT_ARBITER_ROUNDROBIN_EN for round-robin tie
// breaking. Without it, requester 0 always wins ties (fixed priority).
module sc_shift_arbiter #(
    parameter int unsigned HOLDOFF_CYCLES = 4
) (
    input  logic       SC_STATEMACHINE_JUG1_CLOCK_50,
    input  logic       SC_STATEMACHINE_JUG1_RESET_InHigh,
    input  logic [1:0] SC_SHIFT_ARBITER_req0_shiftselection_In,
    input  logic       SC_SHIFT_ARBITER_req0_clear_InLow,
    input  logic [1:0] SC_SHIFT_ARBITER_req1_shiftselection_In,
    input  logic       SC_SHIFT_ARBITER_req1_clear_InLow,
    output logic [1:0] SC_SHIFT_ARBITER_shiftselection_Out,
    output logic       SC_SHIFT_ARBITER_clear_OutLow,
    output logic       SC_SHIFT_ARBITER_grant0_Out,
    output logic       SC_SHIFT_ARBITER_grant1_Out,
    output logic       SC_SHIFT_ARBITER_busy_Out,
    output logic       SC_SHIFT_ARBITER_overflow_Out
);

    localparam int unsigned SEL_W  = 2;
    localparam int unsigned CNT_W  = 8;
    localparam int unsigned NUM_RQ = 2;

    localparam logic [SEL_W-1:0] SEL_LEFT  = 2'b01;
    localparam logic [SEL_W-1:0] SEL_RIGHT = 2'b10;
    localparam logic [SEL_W-1:0] SEL_HOLD  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_GRANT0 = 2'd1,
        ST_GRANT1 = 2'd2,
        ST_HOLD   = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        CMD_LEFT  = 2'd0,
        CMD_RIGHT = 2'd1,
        CMD_CLEAR = 2'd2
    } cmd_t;

    logic clk;
    logic rst;

    assign clk = SC_STATEMACHINE_JUG1_CLOCK_50;
    assign rst = SC_STATEMACHINE_JUG1_RESET_InHigh;

    // Per-requester raw inputs gathered into arrays for the generate loop
    logic [SEL_W-1:0] sel_in   [NUM_RQ];
    logic             clr_n_in [NUM_RQ];

    assign sel_in[0]   = SC_SHIFT_ARBITER_req0_shiftselection_In;
    assign sel_in[1]   = SC_SHIFT_ARBITER_req1_shiftselection_In;
    assign clr_n_in[0] = SC_SHIFT_ARBITER_req0_clear_InLow;
    assign clr_n_in[1] = SC_SHIFT_ARBITER_req1_clear_InLow;

    // FSM and output register state
    state_t           state_q,  state_d;
    logic [CNT_W-1:0] cnt_q,    cnt_d;
    logic [SEL_W-1:0] sel_q,    sel_d;
    logic             clr_n_q,  clr_n_d;
    logic [1:0]       grant_q,  grant_d;
    logic             busy_q,   busy_d;
    logic             ovf_q,    ovf_d;

    // Pending slots and their interaction with the FSM
    logic [NUM_RQ-1:0] pend_vld_q;
    logic [NUM_RQ-1:0] pend_vld_d;
    cmd_t              pend_cmd_q [NUM_RQ];
    cmd_t              pend_cmd_d [NUM_RQ];
    logic [NUM_RQ-1:0] req_vld_c;
    cmd_t              req_cmd_c  [NUM_RQ];
    logic [NUM_RQ-1:0] take_c;
    logic [NUM_RQ-1:0] drop_c;
    logic              pick0_c;

    // Command to datapath shift selection; CLEAR holds the shift lines
    function automatic logic [SEL_W-1:0] cmd_to_sel(input cmd_t cmd);
        logic [SEL_W-1:0] sel;
        sel = SEL_HOLD;
        if (cmd == CMD_LEFT) begin
            sel = SEL_LEFT;
        end else if (cmd == CMD_RIGHT) begin
            sel = SEL_RIGHT;
        end
        return sel;
    endfunction

    for (genvar g = 0; g < NUM_RQ; g++) begin : g_req

        // Request decode: clear wins over a simultaneous shift
        always_comb begin
            req_vld_c[g] = 1'b0;
            req_cmd_c[g] = CMD_LEFT;
            if (!clr_n_in[g]) begin
                req_vld_c[g] = 1'b1;
                req_cmd_c[g] = CMD_CLEAR;
            end else if (sel_in[g] == SEL_LEFT) begin
                req_vld_c[g] = 1'b1;
                req_cmd_c[g] = CMD_LEFT;
            end else if (sel_in[g] == SEL_RIGHT) begin
                req_vld_c[g] = 1'b1;
                req_cmd_c[g] = CMD_RIGHT;
            end
        end

        // Slot update: granting frees the slot on the same edge a new request may refill it
        always_comb begin
            pend_vld_d[g] = pend_vld_q[g] & ~take_c[g];
            pend_cmd_d[g] = pend_cmd_q[g];
            drop_c[g]     = 1'b0;
            if (req_vld_c[g]) begin
                if (pend_vld_q[g] && !take_c[g]) begin
                    drop_c[g] = 1'b1;
                end else begin
                    pend_vld_d[g] = 1'b1;
                    pend_cmd_d[g] = req_cmd_c[g];
                end
            end
        end

        // Slot registers
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                pend_vld_q[g] <= 1'b0;
                pend_cmd_q[g] <= CMD_LEFT;
            end else begin
                pend_vld_q[g] <= pend_vld_d[g];
                pend_cmd_q[g] <= pend_cmd_d[g];
            end
        end

    end : g_req

`ifdef SC_SHIFT_ARBITER_ROUNDROBIN_EN
    // last_q = 1 means requester 1 was served last, so requester 0 wins the next tie
    logic last_q, last_d;

    // Tie break toward the requester not served last
    always_comb begin
        pick0_c = pend_vld_q[0] & (~pend_vld_q[1] | last_q);
    end

    // Last-served pointer follows every grant
    always_comb begin
        last_d = last_q;
        if (take_c[0]) begin
            last_d = 1'b0;
        end else if (take_c[1]) begin
            last_d = 1'b1;
        end
    end

    // Last-served pointer register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end
`else
    // Fixed priority: requester 0 wins whenever it has a pending command
    always_comb begin
        pick0_c = pend_vld_q[0];
    end
`endif

    // Next-state and registered-output decode
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        take_c  = '0;
        sel_d   = SEL_HOLD;
        clr_n_d = 1'b1;
        grant_d = 2'b00;
        case (state_q)
            ST_IDLE: begin
                if (pick0_c) begin
                    state_d = ST_GRANT0;
                    take_c  = 2'b01;
                    grant_d = 2'b01;
                    sel_d   = cmd_to_sel(pend_cmd_q[0]);
                    clr_n_d = (pend_cmd_q[0] != CMD_CLEAR);
                end else if (pend_vld_q[1]) begin
                    state_d = ST_GRANT1;
                    take_c  = 2'b10;
                    grant_d = 2'b10;
                    sel_d   = cmd_to_sel(pend_cmd_q[1]);
                    clr_n_d = (pend_cmd_q[1] != CMD_CLEAR);
                end
            end
            ST_GRANT0, ST_GRANT1: begin
                if (HOLDOFF_CYCLES == 0) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_HOLD;
                    cnt_d   = CNT_W'(HOLDOFF_CYCLES - 1);
                end
            end
            ST_HOLD: begin
                if (cnt_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
        ovf_d  = |drop_c;
    end

    // State, hold-off counter and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            sel_q   <= SEL_HOLD;
            clr_n_q <= 1'b1;
            grant_q <= 2'b00;
            busy_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sel_q   <= sel_d;
            clr_n_q <= clr_n_d;
            grant_q <= grant_d;
            busy_q  <= busy_d;
            ovf_q   <= ovf_d;
        end
    end

    assign SC_SHIFT_ARBITER_shiftselection_Out = sel_q;
    assign SC_SHIFT_ARBITER_clear_OutLow       = clr_n_q;
    assign SC_SHIFT_ARBITER_grant0_Out         = grant_q[0];
    assign SC_SHIFT_ARBITER_grant1_Out         = grant_q[1];
    assign SC_SHIFT_ARBITER_busy_Out           = busy_q;
    assign SC_SHIFT_ARBITER_overflow_Out       = ovf_q;

endmodule : sc_shift_arbiter

// File: tb/tb_sc_shift_arbiter.sv
// Testbench for sc_shift_arbiter: directed scenarios plus random traffic, checked
// by a transaction-level reference model feeding a scoreboard of expected grants
// and overflow pulses.
module tb_sc_shift_arbiter;

    localparam int unsigned H = 4;
`ifdef SC_SHIFT_ARBITER_ROUNDROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] s0 = 2'b11;
    logic [1:0] s1 = 2'b11;
    logic       c0 = 1'b1;
    logic       c1 = 1'b1;
    logic [1:0] sel_o;
    logic       clr_o, g0, g1, busy_o, ovf_o;

    sc_shift_arbiter #(.HOLDOFF_CYCLES(H)) dut (
        .SC_STATEMACHINE_JUG1_CLOCK_50          (clk),
        .SC_STATEMACHINE_JUG1_RESET_InHigh      (rst),
        .SC_SHIFT_ARBITER_req0_shiftselection_In(s0),
        .SC_SHIFT_ARBITER_req0_clear_InLow      (c0),
        .SC_SHIFT_ARBITER_req1_shiftselection_In(s1),
        .SC_SHIFT_ARBITER_req1_clear_InLow      (c1),
        .SC_SHIFT_ARBITER_shiftselection_Out    (sel_o),
        .SC_SHIFT_ARBITER_clear_OutLow          (clr_o),
        .SC_SHIFT_ARBITER_grant0_Out            (g0),
        .SC_SHIFT_ARBITER_grant1_Out            (g1),
        .SC_SHIFT_ARBITER_busy_Out              (busy_o),
        .SC_SHIFT_ARBITER_overflow_Out          (ovf_o)
    );

    initial forever #5 clk = ~clk;

    typedef struct {
        int         tag;
        int         id;
        logic [1:0] sel;
        logic       clr;
    } gexp_t;

    gexp_t gq[$];
    int    oq[$];
    int    passed = 0;
    int    total  = 0;
    int    e      = 0;

    // Reference model state: slot contents as the datapath will see them
    bit         mv   [2];
    logic [1:0] msel [2];
    logic       mclr [2];
    int         mlast   = 1;
    int         next_ok = 0;
    int         last_g  = -1000;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            $display("FAIL %s edge %0d: got %h expected %h", name, e, got, exp);
        end else begin
            passed++;
        end
    endtask

    // Reference model: each edge, grant if the datapath is free, then absorb requests
    always @(posedge clk) begin
        int    w;
        bit    dropped;
        gexp_t x;
        bit    rv [2];
        logic [1:0] rs [2];
        logic       rc [2];
        e++;
        if (rst) begin
            mv      = '{1'b0, 1'b0};
            mlast   = 1;
            next_ok = 0;
            last_g  = -1000;
            gq.delete();
            oq.delete();
        end else begin
            w = -1;
            if (e >= next_ok) begin
                if (mv[0] && mv[1]) w = (RR && mlast == 0) ? 1 : 0;
                else if (mv[0])     w = 0;
                else if (mv[1])     w = 1;
            end
            if (w >= 0) begin
                x.tag = e; x.id = w; x.sel = msel[w]; x.clr = mclr[w];
                gq.push_back(x);
                mv[w]   = 1'b0;
                mlast   = w;
                next_ok = e + H + 2;
                last_g  = e;
            end
            rs[0] = s0; rc[0] = c0; rs[1] = s1; rc[1] = c1;
            dropped = 1'b0;
            for (int i = 0; i < 2; i++) begin
                rv[i] = !rc[i] || rs[i] == 2'b01 || rs[i] == 2'b10;
                if (rv[i]) begin
                    if (mv[i]) begin
                        dropped = 1'b1;
                    end else begin
                        mv[i]   = 1'b1;
                        msel[i] = rc[i] ? rs[i] : 2'b11;
                        mclr[i] = rc[i];
                    end
                end
            end
            if (dropped) oq.push_back(e);
        end
    end

    // Monitor: compares DUT outputs against the scoreboard each cycle
    initial forever begin
        gexp_t x;
        logic [4:0] exp_v;
        @(posedge clk);
        #1;
        if (!rst) begin
            if (gq.size() > 0 && gq[0].tag == e) begin
                x = gq.pop_front();
                exp_v = {x.id == 0, x.id == 1, x.sel, x.clr};
                chk("grant", 32'({g0, g1, sel_o, clr_o}), 32'(exp_v));
            end else begin
                chk("idle_out", 32'({g0, g1, sel_o, clr_o}), 32'(5'b00111));
            end
            chk("busy", 32'(busy_o), 32'((e - last_g) <= int'(H)));
            if (oq.size() > 0 && oq[0] == e) begin
                void'(oq.pop_front());
                chk("overflow", 32'(ovf_o), 32'(1));
            end else begin
                chk("no_overflow", 32'(ovf_o), 32'(0));
            end
        end
    end

    task automatic drive(input logic [1:0] a, input logic ca, input logic [1:0] b, input logic cb);
        @(negedge clk);
        s0 = a; c0 = ca; s1 = b; c1 = cb;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(2'b11, 1'b1, 2'b11, 1'b1);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("reset_state", 32'({sel_o, clr_o, g0, g1, busy_o, ovf_o}), 32'(7'b1110000));
        @(negedge clk);
        rst = 1'b0;
        idle(3);

        // Single req0 LEFT
        drive(2'b01, 1'b1, 2'b11, 1'b1);
        idle(12);

        // Ties repeated at the grant spacing
        for (int k = 0; k < 3; k++) begin
            drive(2'b10, 1'b1, 2'b01, 1'b1);
            idle(H + 1);
        end
        idle(30);

        // Clear beats a simultaneous shift on requester 1
        drive(2'b11, 1'b1, 2'b01, 1'b0);
        idle(12);

        // Two req0 requests during one HOLD: second is dropped
        drive(2'b01, 1'b1, 2'b11, 1'b1);
        idle(1);
        drive(2'b10, 1'b1, 2'b11, 1'b1);
        drive(2'b01, 1'b1, 2'b11, 1'b1);
        idle(20);

        // Request on the edge GRANT0 is entered is captured
        drive(2'b01, 1'b1, 2'b11, 1'b1);
        drive(2'b10, 1'b1, 2'b11, 1'b1);
        idle(20);

        // Reset during HOLD with req1 pending
        drive(2'b01, 1'b1, 2'b11, 1'b1);
        idle(1);
        drive(2'b11, 1'b1, 2'b10, 1'b1);
        @(negedge clk);
        s0 = 2'b11; c0 = 1'b1; s1 = 2'b11; c1 = 1'b1;
        rst = 1'b1;
        #1;
        chk("reset_async", 32'({sel_o, clr_o, g0, g1, busy_o, ovf_o}), 32'(7'b1110000));
        idle(2);
        @(negedge clk);
        rst = 1'b0;
        idle(20);

        // Random traffic
        for (int n = 0; n < 600; n++) begin
            logic [1:0] a, b;
            logic       ca, cb;
            a  = ($urandom_range(0, 99) < 30) ? 2'($urandom) : 2'b11;
            b  = ($urandom_range(0, 99) < 30) ? 2'($urandom) : 2'b11;
            ca = ($urandom_range(0, 99) >= 8);
            cb = ($urandom_range(0, 99) >= 8);
            drive(a, ca, b, cb);
        end
        idle(30);

        @(negedge clk);
        chk("grants_drained", 32'(gq.size()), 32'(0));
        chk("overflows_drained", 32'(oq.size()), 32'(0));
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule : tb_sc_shift_arbiter
